mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Parametrised MEM pipeline stage: EX/MEM register, byte-addressed data memory with
//  byte/half/word access, configurable wait states with upstream stall, and gated branch
//  resolution. Sits between the EX stage and the MEM/WB register of the 5-stage CPU.
//  Adds valid/flush/stall handshake and misalignment detection.
// PARAMETERS
//  ADDR_W      8  word-index width; memory depth = 2**ADDR_W 32-bit words
//  WAIT_STATES 0  extra cycles per load/store (0..15); 0 = single-cycle access
//  TAG_W       4  width of ins_type / ins_number debug tags
// PORTS
//  clk            in  1        rising-edge clock
//  rst_n          in  1        asynchronous reset, active low
//  ex_valid       in  1        EX holds a real instruction
//  ex_flush       in  1        capture a bubble at the next capture edge
//  ex_destR       in  5        destination register
//  ex_aluR        in  32       ALU result / byte address
//  ex_inB         in  32       store data
//  ex_wreg ex_m2reg ex_wmem  in 1 each  reg-write, load, store controls
//  ex_size        in  2        00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  ex_lsign       in  1        1 = sign-extend sub-word load
//  ex_branch ex_zero in 1 each  branch op, ALU zero flag
//  ex_pc          in  32       branch target
//  ex_ins_type ex_ins_number in TAG_W each  debug tags
//  mem_busy       out 1        stall EX/ID/IF this cycle
//  mem_valid      out 1        entry complete and presented to MEM/WB
//  mem_wreg mem_m2reg out 1 each  registered controls, gated by mem_valid
//  mem_destR      out 5;  mem_aluR out 32;  mem_pc out 32
//  mem_mdata      out 32       extended load data
//  mem_branch     out 1        mem_valid & branch & zero
//  mem_misalign   out 1        completed access was misaligned
//  mem_ins_type mem_ins_number out TAG_W each
// BEHAVIOUR
//  - Reset: every output 0, entry invalid, FSM IDLE, wait counter 0; memory array not reset.
//  - Capture edge = rising clk with mem_busy=0. Register loads all ex_* fields;
//    entry valid <= ex_valid & ~ex_flush. ex_flush is sampled only on capture edges.
//  - FSM: IDLE -> (captured valid load/store and WAIT_STATES>0) WAIT, counter=WAIT_STATES;
//    WAIT decrements each cycle; WAIT -> IDLE when counter reaches 0.
//  - mem_busy = (state==WAIT); the entry is held, not overwritten, while busy.
//  - mem_valid = entry valid & state==IDLE. Non-memory ops complete the cycle after capture.
//  - Latency: capture edge to mem_valid = 1 + WAIT_STATES cycles for load/store.
//  - Address: byte addr = aluR; word index = aluR[ADDR_W+1:2]; upper bits ignored (wrap).
//  - Misaligned: half with aluR[0]=1, word with aluR[1:0]!=0 -> mem_misalign=1 with
//    mem_valid; store suppressed, mem_mdata=0, mem_wreg forced 0.
//  - Load: combinational read of indexed word; select lane by aluR[1:0]/size; zero- or
//    sign-extend per lsign. Little-endian lanes (byte 0 = bits 7:0).
//  - Store: byte-enable write of inB low bytes into the addressed lanes, committed at the
//    rising edge ending the mem_valid cycle; exactly one write per store.
//  - Load after store to same word in next entry reads the new data.
//  - Reset mid-WAIT: entry dropped, pending store never committed.
//  - mem_branch asserted only with mem_valid; bubbles never branch or write.
// CONFIGURATION
//  MEM_FWD_EN defined: extra outputs mem_fwd_en (1) = mem_valid & mem_wreg,
//   mem_fwd_reg (5) = mem_destR, mem_fwd_data (32) = m2reg ? mem_mdata : mem_aluR,
//   for EX-stage operand forwarding; all reset to 0.
//  MEM_FWD_EN undefined: ports absent; no forwarding logic.
// TESTING
//  1 WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_mdata=0xDEADBEEF, busy never 1.
//  2 SB 0x80 @0x13 over word 0 then LB signed @0x13 -> 0xFFFFFF80; LBU -> 0x00000080;
//    LW @0x10 -> 0x80ADBEEF.
//  3 WAIT_STATES=3: LW captured -> mem_busy high 3 cycles, mem_valid 4th cycle, EX held.
//  4 SH @0x21 -> mem_misalign=1, memory unchanged, mem_wreg=0; LH @0x22 aligned ok.
//  5 branch=1 zero=1 with ex_flush at capture -> mem_branch stays 0; without flush -> 1
//    for one cycle, mem_pc=target.
//  6 rst_n low during WAIT of SW -> outputs 0 immediately; later LW shows old word.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM entry register, byte-addressed data memory with wait states,
// misalignment detection and gated branch resolution. Optional forwarding outputs: MEM_FWD_EN.
module mem_access_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int TAG_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [4:0]        ex_destR,
    input  logic [31:0]       ex_aluR,
    input  logic [31:0]       ex_inB,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic              ex_wmem,
    input  logic [1:0]        ex_size,
    input  logic              ex_lsign,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [31:0]       ex_pc,
    input  logic [TAG_W-1:0]  ex_ins_type,
    input  logic [TAG_W-1:0]  ex_ins_number,
    output logic              mem_busy,
    output logic              mem_valid,
    output logic              mem_wreg,
    output logic              mem_m2reg,
    output logic [4:0]        mem_destR,
    output logic [31:0]       mem_aluR,
    output logic [31:0]       mem_pc,
    output logic [31:0]       mem_mdata,
    output logic              mem_branch,
    output logic              mem_misalign,
`ifdef MEM_FWD_EN
    output logic              mem_fwd_en,
    output logic [4:0]        mem_fwd_reg,
    output logic [31:0]       mem_fwd_data,
`endif
    output logic [TAG_W-1:0]  mem_ins_type,
    output logic [TAG_W-1:0]  mem_ins_number
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_CNT   = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       dest_r;
        logic [31:0]      alu_r;
        logic [31:0]      in_b;
        logic             wreg;
        logic             m2reg;
        logic             wmem;
        logic [1:0]       size;
        logic             lsign;
        logic             branch;
        logic             zero;
        logic [31:0]      pc;
        logic [TAG_W-1:0] ins_type;
        logic [TAG_W-1:0] ins_number;
    } entry_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    entry_t      entry_q, entry_d;

    logic [31:0]       mem_array [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       load_data;
    logic [31:0]       wdata;
    logic [3:0]        byte_en;
    logic              misalign;
    logic              store_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
        end
    end

    // The entry only reloads while idle, so a waiting access keeps its fields intact.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        case (state_q)
            S_IDLE: begin
                entry_d.valid      = ex_valid & ~ex_flush;
                entry_d.dest_r     = ex_destR;
                entry_d.alu_r      = ex_aluR;
                entry_d.in_b       = ex_inB;
                entry_d.wreg       = ex_wreg;
                entry_d.m2reg      = ex_m2reg;
                entry_d.wmem       = ex_wmem;
                entry_d.size       = ex_size;
                entry_d.lsign      = ex_lsign;
                entry_d.branch     = ex_branch;
                entry_d.zero       = ex_zero;
                entry_d.pc         = ex_pc;
                entry_d.ins_type   = ex_ins_type;
                entry_d.ins_number = ex_ins_number;
                if (HAS_WAIT && ex_valid && !ex_flush && (ex_m2reg || ex_wmem)) begin
                    state_d = S_WAIT;
                    cnt_d   = WS_CNT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_idx = entry_q.alu_r[ADDR_W+1:2];
        rd_word  = mem_array[word_idx];
        misalign = (entry_q.m2reg || entry_q.wmem) &&
                   (((entry_q.size == 2'b01) && entry_q.alu_r[0]) ||
                    (entry_q.size[1] && (entry_q.alu_r[1:0] != 2'b00)));

        load_data = rd_word;
        wdata     = entry_q.in_b;
        byte_en   = 4'b1111;
        case (entry_q.size)
            2'b00: begin
                case (entry_q.alu_r[1:0])
                    2'd0:    load_data = {{24{entry_q.lsign & rd_word[7]}},  rd_word[7:0]};
                    2'd1:    load_data = {{24{entry_q.lsign & rd_word[15]}}, rd_word[15:8]};
                    2'd2:    load_data = {{24{entry_q.lsign & rd_word[23]}}, rd_word[23:16]};
                    default: load_data = {{24{entry_q.lsign & rd_word[31]}}, rd_word[31:24]};
                endcase
                wdata   = {4{entry_q.in_b[7:0]}};
                byte_en = 4'b0001 << entry_q.alu_r[1:0];
            end
            2'b01: begin
                if (entry_q.alu_r[1])
                    load_data = {{16{entry_q.lsign & rd_word[31]}}, rd_word[31:16]};
                else
                    load_data = {{16{entry_q.lsign & rd_word[15]}}, rd_word[15:0]};
                wdata   = {2{entry_q.in_b[15:0]}};
                byte_en = entry_q.alu_r[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase

        mem_busy       = (state_q == S_WAIT);
        mem_valid      = entry_q.valid && (state_q == S_IDLE);
        mem_wreg       = mem_valid && entry_q.wreg && !misalign;
        mem_m2reg      = mem_valid && entry_q.m2reg;
        mem_destR      = entry_q.dest_r;
        mem_aluR       = entry_q.alu_r;
        mem_pc         = entry_q.pc;
        mem_mdata      = (mem_valid && entry_q.m2reg && !misalign) ? load_data : 32'd0;
        mem_branch     = mem_valid && entry_q.branch && entry_q.zero;
        mem_misalign   = mem_valid && misalign;
        mem_ins_type   = entry_q.ins_type;
        mem_ins_number = entry_q.ins_number;
        store_en       = mem_valid && entry_q.wmem && !misalign;
`ifdef MEM_FWD_EN
        mem_fwd_en     = mem_valid && mem_wreg;
        mem_fwd_reg    = mem_destR;
        mem_fwd_data   = mem_m2reg ? mem_mdata : mem_aluR;
`endif
    end

    // Store commits on the edge that ends the mem_valid cycle, so it happens exactly once.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_array[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
